// File: rtl/wd279x_fdc_if.sv
// CPU register window, drive status and block-storage handshake of the WD279x FDC core.
// The slave modport is the controller's view; master is the host/storage side.
interface wd279x_fdc_if #(
    parameter int DRIVES      = 2,
    parameter int SECTOR_SIZE = 512
);
    localparam int DW = (DRIVES > 1) ? $clog2(DRIVES) : 1;
    localparam int AW = $clog2(SECTOR_SIZE);

    logic [1:0]        addr;
    logic [7:0]        cpu_din;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [7:0]        cpu_dout;
    logic [DW-1:0]     drive_sel;
    logic              side;
    logic [DRIVES-1:0] mounted;
    logic [DRIVES-1:0] wprot;
    logic              intrq;
    logic              drq;
    logic [31:0]       blk_lba;
    logic              blk_rd;
    logic              blk_wr;
    logic              blk_ack;
    logic [AW-1:0]     buf_addr;
    logic              buf_we;
    logic [7:0]        buf_din;
    logic [7:0]        buf_dout;

    modport slave (
        input  addr, cpu_din, cpu_wr, cpu_rd, drive_sel, side, mounted, wprot,
        input  blk_ack, buf_addr, buf_we, buf_din,
        output cpu_dout, intrq, drq, blk_lba, blk_rd, blk_wr, buf_dout
    );

    modport master (
        output addr, cpu_din, cpu_wr, cpu_rd, drive_sel, side, mounted, wprot,
        output blk_ack, buf_addr, buf_we, buf_din,
        input  cpu_dout, intrq, drq, blk_lba, blk_rd, blk_wr, buf_dout
    );
endinterface

// File: rtl/wd279x_fdc.sv
// WD279x-compatible floppy controller: Type I head positioning and Type II sector transfers
// against a block-addressed image, staged through a one-sector buffer.
module wd279x_fdc #(
    parameter int DRIVES            = 2,
    parameter int SECTOR_SIZE       = 512,
    parameter int SECTORS_PER_TRACK = 9,
    parameter int TRACKS            = 80,
    parameter int SIDES             = 2,
    parameter int STEP_CYCLES       = 3000
) (
    input logic         clk,
    input logic         rst_n,
    wd279x_fdc_if.slave bus
);
    localparam int AW = $clog2(SECTOR_SIZE);

    typedef enum logic [2:0] {
        StIdle, StStepWait, StCheck, StBlkReq, StXferRd, StXferWr, StDone
    } state_t;

    state_t        r_state;
    logic [7:0]    r_track, r_sector, r_data;
    logic [3:0]    r_cmd;
    logic [7:0]    r_head [DRIVES];
    logic          r_busy, r_intrq, r_drq, r_blk_rd, r_blk_wr;
    logic          r_trk0, r_rnf, r_wp, r_type1, r_dir_out, r_load;
    logic [31:0]   r_lba;
    logic [31:0]   r_step_cnt;
    logic [7:0]    r_nsteps;
    logic [AW-1:0] r_idx;
    logic [7:0]    r_mem [SECTOR_SIZE];
    logic [7:0]    r_buf_dout;

    logic        w_cmd_wr, w_force, w_dat_rd, w_dat_wr;
    logic        w_need_step, w_out, w_upd_trk;
    logic [7:0]  w_head, w_next_head, w_next_track, w_status;
    logic [31:0] w_lba;

    assign w_cmd_wr = bus.cpu_wr && (bus.addr == 2'd0);
    assign w_force  = w_cmd_wr && (bus.cpu_din[7:4] == 4'hD);
    assign w_dat_rd = bus.cpu_rd && (bus.addr == 2'd3);
    assign w_dat_wr = bus.cpu_wr && (bus.addr == 2'd3);
    assign w_head   = r_head[bus.drive_sel];
    assign w_lba    = (32'(r_track) * 32'(SIDES) + 32'(bus.side)) * 32'(SECTORS_PER_TRACK)
                    + 32'(r_sector) - 32'd1;

    // Per-command step decision: restore always heads out, seek toward the data register.
    always_comb begin
        w_need_step = 1'b0;
        w_out       = r_dir_out;
        w_upd_trk   = 1'b0;
        if (r_cmd == 4'h0) begin
            w_need_step = (w_head != 8'd0) && (r_nsteps != 8'd255);
            w_out       = 1'b1;
        end else if (r_cmd == 4'h1) begin
            w_need_step = (r_track != r_data);
            w_out       = (r_data < r_track);
            w_upd_trk   = 1'b1;
        end else begin
            w_need_step = (r_nsteps == 8'd0);
            w_upd_trk   = r_cmd[0];
        end
        if (w_out) w_next_head = (w_head == 8'd0) ? 8'd0 : w_head - 8'd1;
        else       w_next_head = (32'(w_head) >= TRACKS - 1) ? w_head : w_head + 8'd1;
        if (w_out) w_next_track = (r_track == 8'd0) ? 8'd0 : r_track - 8'd1;
        else       w_next_track = r_track + 8'd1;
    end

    assign w_status = {~bus.mounted[bus.drive_sel], r_wp, 1'b0, r_rnf, 1'b0, r_trk0,
                       r_drq, r_busy};

    always_comb begin
        bus.cpu_dout = w_status;
        case (bus.addr)
            2'd1:    bus.cpu_dout = r_track;
            2'd2:    bus.cpu_dout = r_sector;
            2'd3:    bus.cpu_dout = r_data;
            default: bus.cpu_dout = w_status;
        endcase
    end

    assign bus.intrq    = r_intrq;
    assign bus.drq      = r_drq;
    assign bus.blk_lba  = r_lba;
    assign bus.blk_rd   = r_blk_rd;
    assign bus.blk_wr   = r_blk_wr;
    assign bus.buf_dout = r_buf_dout;

    always_ff @(posedge clk) begin
        if (bus.buf_we) r_mem[bus.buf_addr] <= bus.buf_din;
        if (r_state == StXferWr && r_drq && w_dat_wr) r_mem[r_idx] <= bus.cpu_din;
        r_buf_dout <= r_mem[bus.buf_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_track    <= '0;
            r_sector   <= '0;
            r_data     <= '0;
            r_cmd      <= '0;
            for (int i = 0; i < DRIVES; i++) r_head[i] <= '0;
            r_busy     <= 1'b0;
            r_intrq    <= 1'b0;
            r_drq      <= 1'b0;
            r_blk_rd   <= 1'b0;
            r_blk_wr   <= 1'b0;
            r_trk0     <= 1'b0;
            r_rnf      <= 1'b0;
            r_wp       <= 1'b0;
            r_type1    <= 1'b0;
            r_dir_out  <= 1'b0;
            r_load     <= 1'b0;
            r_lba      <= '0;
            r_step_cnt <= '0;
            r_nsteps   <= '0;
            r_idx      <= '0;
        end else begin
            if (bus.cpu_rd && bus.addr == 2'd0) r_intrq <= 1'b0;
            if (!r_busy && bus.cpu_wr) begin
                if (bus.addr == 2'd1) r_track  <= bus.cpu_din;
                if (bus.addr == 2'd2) r_sector <= bus.cpu_din;
                if (bus.addr == 2'd3) r_data   <= bus.cpu_din;
            end
            // Abort has priority over everything, including a coincident blk_ack.
            if (w_force) begin
                r_state  <= StIdle;
                r_cmd    <= bus.cpu_din[7:4];
                r_busy   <= 1'b0;
                r_drq    <= 1'b0;
                r_blk_rd <= 1'b0;
                r_blk_wr <= 1'b0;
                r_load   <= 1'b0;
                r_intrq  <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: if (w_cmd_wr) begin
                        r_cmd      <= bus.cpu_din[7:4];
                        r_intrq    <= 1'b0;
                        r_trk0     <= 1'b0;
                        r_rnf      <= 1'b0;
                        r_wp       <= 1'b0;
                        r_nsteps   <= '0;
                        r_step_cnt <= '0;
                        if (!bus.cpu_din[7]) begin
                            r_busy  <= 1'b1;
                            r_type1 <= 1'b1;
                            r_state <= StStepWait;
                            if (bus.cpu_din[7:5] == 3'b010) r_dir_out <= 1'b0;
                            if (bus.cpu_din[7:5] == 3'b011) r_dir_out <= 1'b1;
                        end else if (bus.cpu_din[7:6] == 2'b10) begin
                            r_busy  <= 1'b1;
                            r_type1 <= 1'b0;
                            r_state <= StCheck;
                        end else begin
                            r_intrq <= 1'b1;
                        end
                    end
                    StStepWait: begin
                        if (!w_need_step) begin
                            if (r_cmd == 4'h0) r_track <= '0;
                            r_state <= StDone;
                        end else if (r_step_cnt == 32'(STEP_CYCLES - 1)) begin
                            r_step_cnt              <= '0;
                            r_head[bus.drive_sel]   <= w_next_head;
                            r_nsteps                <= r_nsteps + 8'd1;
                            if (w_upd_trk) r_track  <= w_next_track;
                        end else begin
                            r_step_cnt <= r_step_cnt + 32'd1;
                        end
                    end
                    StCheck: begin
                        if (!bus.mounted[bus.drive_sel] || r_sector == 8'd0 ||
                            32'(r_sector) > SECTORS_PER_TRACK || 32'(r_track) >= TRACKS) begin
                            r_rnf   <= 1'b1;
                            r_state <= StDone;
                        end else if (r_cmd[1] && bus.wprot[bus.drive_sel]) begin
                            r_wp    <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_lba <= w_lba;
                            r_idx <= '0;
                            if (r_cmd[1]) begin
                                r_drq   <= 1'b1;
                                r_state <= StXferWr;
                            end else begin
                                r_blk_rd <= 1'b1;
                                r_state  <= StBlkReq;
                            end
                        end
                    end
                    StBlkReq: if (bus.blk_ack) begin
                        r_blk_rd <= 1'b0;
                        r_blk_wr <= 1'b0;
                        if (r_blk_rd) begin
                            r_idx   <= '0;
                            r_load  <= 1'b1;
                            r_state <= StXferRd;
                        end else begin
                            r_state <= StDone;
                        end
                    end
                    StXferRd: begin
                        if (r_load) begin
                            r_data <= r_mem[r_idx];
                            r_drq  <= 1'b1;
                            r_load <= 1'b0;
                        end else if (r_drq && w_dat_rd) begin
                            r_drq <= 1'b0;
                            if (r_idx == AW'(SECTOR_SIZE - 1)) begin
                                r_state <= StDone;
                            end else begin
                                r_idx  <= r_idx + 1'b1;
                                r_load <= 1'b1;
                            end
                        end
                    end
                    StXferWr: if (r_drq && w_dat_wr) begin
                        r_data <= bus.cpu_din;
                        if (r_idx == AW'(SECTOR_SIZE - 1)) begin
                            r_drq    <= 1'b0;
                            r_blk_wr <= 1'b1;
                            r_state  <= StBlkReq;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    StDone: begin
                        r_busy  <= 1'b0;
                        r_drq   <= 1'b0;
                        r_intrq <= 1'b1;
                        if (r_type1) r_trk0 <= (w_head == 8'd0);
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wd279x_fdc.sv
// Directed bench for wd279x_fdc: head positioning, sector read/write through the buffer,
// error paths and force-interrupt, with a byte scoreboard queue.
module tb_wd279x_fdc;
    localparam int SC  = 3000;
    localparam int SSZ = 512;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic seen_rd, seen_wr;
    logic [7:0] exp_q [$];
    logic [7:0] rd;
    logic [7:0] b;
    int   n;

    always #5 clk = ~clk;

    wd279x_fdc_if #(.DRIVES(2), .SECTOR_SIZE(SSZ)) bus ();

    wd279x_fdc #(
        .DRIVES(2), .SECTOR_SIZE(SSZ), .SECTORS_PER_TRACK(9), .TRACKS(80), .SIDES(2),
        .STEP_CYCLES(SC)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        seen_rd = seen_rd | bus.blk_rd;
        seen_wr = seen_wr | bus.blk_wr;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.cpu_din = d;
        bus.cpu_wr  = 1'b1;
        tick();
        bus.cpu_wr  = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        bus.addr   = a;
        #1;
        d          = bus.cpu_dout;
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
    endtask

    // which: 0 intrq, 1 drq, 2 blk_rd, 3 blk_wr
    task automatic wait_for(input int which, input int bound, input string tag);
        logic s;
        int   k;
        k = 0;
        s = 1'b0;
        while (k < bound) begin
            case (which)
                0: s = bus.intrq;
                1: s = bus.drq;
                2: s = bus.blk_rd;
                default: s = bus.blk_wr;
            endcase
            if (s) break;
            tick();
            k++;
        end
        if (!s) check(tag, 32'(s), 32'd1);
    endtask

    task automatic pulse_ack();
        bus.blk_ack = 1'b1;
        tick();
        bus.blk_ack = 1'b0;
    endtask

    initial begin
        bus.addr = '0; bus.cpu_din = '0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
        bus.drive_sel = '0; bus.side = 1'b0; bus.mounted = 2'b11; bus.wprot = 2'b00;
        bus.blk_ack = 1'b0; bus.buf_addr = '0; bus.buf_we = 1'b0; bus.buf_din = '0;
        seen_rd = 1'b0; seen_wr = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        cpu_read(2'd0, rd);
        check("reset_status", rd, 8'h00);
        check("reset_intrq", bus.intrq, 1'b0);
        check("reset_drq", bus.drq, 1'b0);
        check("reset_blk", {bus.blk_rd, bus.blk_wr}, 2'b00);

        // SEEK to 5, then RESTORE back with timing window
        cpu_write(2'd3, 8'd5);
        cpu_write(2'd0, 8'h10);
        cpu_read(2'd0, rd);
        check("seek_busy", rd, 8'h01);
        wait_for(0, 6 * SC, "seek_intrq");
        cpu_read(2'd1, rd);
        check("seek_track", rd, 8'd5);
        cpu_read(2'd0, rd);
        check("seek_intrq_clr", bus.intrq, 1'b0);

        cpu_write(2'd0, 8'h00);
        n = 0;
        while (!bus.intrq && n < 6 * SC) begin
            tick();
            n++;
        end
        check("restore_timing", 32'((n >= 5 * SC) && (n <= 5 * SC + 20)), 32'd1);
        cpu_read(2'd1, rd);
        check("restore_track", rd, 8'd0);
        cpu_read(2'd0, rd);
        check("restore_status", rd, 8'h04);
        check("restore_intrq_clr", bus.intrq, 1'b0);

        // READ track 2 side 1 sector 3
        bus.side = 1'b1;
        cpu_write(2'd1, 8'd2);
        cpu_write(2'd2, 8'd3);
        seen_rd = 1'b0;
        cpu_write(2'd0, 8'h80);
        wait_for(2, 10, "rd_req");
        check("rd_lba", bus.blk_lba, 32'd47);
        bus.buf_we = 1'b1;
        for (int i = 0; i < SSZ; i++) begin
            bus.buf_addr = 9'(i);
            bus.buf_din  = 8'(i);
            exp_q.push_back(8'(i));
            tick();
        end
        bus.buf_we = 1'b0;
        check("rd_req_held", bus.blk_rd, 1'b1);
        pulse_ack();
        for (int i = 0; i < SSZ; i++) begin
            wait_for(1, 10, "rd_drq");
            cpu_read(2'd3, rd);
            b = exp_q.pop_front();
            check($sformatf("rd_byte%0d", i), rd, b);
        end
        wait_for(0, 10, "rd_intrq");
        cpu_read(2'd0, rd);
        check("rd_done_status", rd, 8'h00);

        // WRITE with write-protect
        bus.wprot = 2'b01;
        seen_wr = 1'b0;
        cpu_write(2'd0, 8'hA0);
        wait_for(0, 10, "wp_intrq");
        check("wp_no_blkwr", seen_wr, 1'b0);
        cpu_read(2'd0, rd);
        check("wp_status", rd, 8'h40);

        // WRITE, then read the buffer back on the storage side
        bus.wprot = 2'b00;
        cpu_write(2'd0, 8'hA0);
        for (int i = 0; i < SSZ; i++) begin
            wait_for(1, 10, "wr_drq");
            b = 8'((i * 7 + 3) & 255);
            exp_q.push_back(b);
            cpu_write(2'd3, b);
        end
        wait_for(3, 10, "wr_req");
        check("wr_lba", bus.blk_lba, 32'd47);
        check("wr_drq_low", bus.drq, 1'b0);
        for (int i = 0; i < SSZ; i++) begin
            bus.buf_addr = 9'(i);
            tick();
            b = exp_q.pop_front();
            check($sformatf("wr_buf%0d", i), bus.buf_dout, b);
        end
        pulse_ack();
        wait_for(0, 10, "wr_intrq");
        cpu_read(2'd0, rd);
        check("wr_done_status", rd, 8'h00);

        // READ with out-of-range sector
        cpu_write(2'd2, 8'd10);
        seen_rd = 1'b0;
        cpu_write(2'd0, 8'h80);
        wait_for(0, 10, "rnf_intrq");
        check("rnf_no_blkrd", seen_rd, 1'b0);
        cpu_read(2'd0, rd);
        check("rnf_status", rd, 8'h10);

        // FORCE-INT during the 100th byte of a READ
        cpu_write(2'd2, 8'd3);
        cpu_write(2'd0, 8'h80);
        wait_for(2, 10, "fi_req");
        pulse_ack();
        for (int i = 0; i < 99; i++) begin
            wait_for(1, 10, "fi_drq");
            cpu_read(2'd3, rd);
        end
        wait_for(1, 10, "fi_drq100");
        cpu_write(2'd0, 8'hD0);
        check("fi_drq", bus.drq, 1'b0);
        check("fi_intrq", bus.intrq, 1'b1);
        cpu_read(2'd0, rd);
        check("fi_status", rd, 8'h00);
        pulse_ack();
        repeat (3) tick();
        check("fi_late_ack_drq", bus.drq, 1'b0);
        cpu_read(2'd0, rd);
        check("fi_late_ack_status", rd, 8'h00);

        // FORCE-INT coincident with blk_ack: abort wins
        cpu_write(2'd0, 8'h80);
        wait_for(2, 10, "fi2_req");
        bus.blk_ack = 1'b1;
        cpu_write(2'd0, 8'hD0);
        bus.blk_ack = 1'b0;
        repeat (3) tick();
        check("fi2_drq", bus.drq, 1'b0);
        check("fi2_blkrd", bus.blk_rd, 1'b0);
        cpu_read(2'd0, rd);
        check("fi2_status", rd, 8'h00);

        // Reset in the middle of a SEEK
        cpu_write(2'd3, 8'd9);
        cpu_write(2'd0, 8'h10);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cpu_read(2'd0, rd);
        check("midrst_status", rd, 8'h00);
        cpu_read(2'd1, rd);
        check("midrst_track", rd, 8'h00);
        check("midrst_intrq", bus.intrq, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
